// File: rtl/i2s_tx_pkg.sv
// rtl/i2s_tx_pkg.sv - shared types, limits and word-select helper for the I2S transmitter
package i2s_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int BCLK_DIV_MIN = 2;

    // Word select leads the data by one bit period: high from the last left bit to the one before last right bit.
    function automatic logic lrclk_of(input int p, input int r);
        return (p >= r - 1) && (p <= 2 * r - 2);
    endfunction

endpackage

// File: rtl/i2s_tx_clkgen.sv
// rtl/i2s_tx_clkgen.sv - bit clock divider for the I2S transmitter with a falling-edge strobe
module i2s_tx_clkgen
    import i2s_tx_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bclk,
    output logic fall_evt
);

    localparam int DIV = (BCLK_DIV < BCLK_DIV_MIN) ? BCLK_DIV_MIN : BCLK_DIV;
    localparam int W   = $clog2(DIV);

    logic [W-1:0] div_cnt;
    logic         tc;

    assign tc = (div_cnt == W'(DIV - 1));
    // Asserted in the cycle before the edge that drops bclk, so users update on that same edge.
    assign fall_evt = run && tc && bclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - mono-to-stereo I2S transmitter; I2S_TX_UNDERRUN_REPEAT_EN repeats the last sample on underrun
module i2s_tx
    import i2s_tx_pkg::*;
#(
    parameter int RESOLUTION = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [RESOLUTION-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  underrun
);

    localparam int PW = $clog2(2 * RESOLUTION);
    localparam int IW = $clog2(RESOLUTION);

    state_t                state;
    logic [PW-1:0]         p;
    logic                  started;
    logic                  hold_valid;
    logic [RESOLUTION-1:0] hold_reg;
    logic [RESOLUTION-1:0] frame_reg;

    logic                  fall_evt;
    logic                  frame_start;
    logic                  accept;
    logic                  to_idle;
    logic                  hold_next;
    logic [PW-1:0]         p_next;
    logic [IW-1:0]         idx;
    logic [RESOLUTION-1:0] load_sample;

    i2s_tx_clkgen #(
        .BCLK_DIV(BCLK_DIV)
    ) u_clkgen (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (state != IDLE),
        .bclk    (bclk),
        .fall_evt(fall_evt)
    );

    always_comb begin
        // The first fall after leaving IDLE opens a frame even though p has not wrapped.
        frame_start = fall_evt && (!started || (p == PW'(2 * RESOLUTION - 1)));
        accept      = valid_in && ready_out;
        to_idle     = (state == DRAIN) && !enable && fall_evt && started
                      && (p == PW'(2 * RESOLUTION - 2));
        p_next      = frame_start ? '0 : p + 1'b1;
        if (to_idle)
            hold_next = 1'b0;
        else if (frame_start)
            hold_next = accept;
        else
            hold_next = hold_valid || accept;
        load_sample = frame_reg;
        if (frame_start) begin
            if (hold_valid)
                load_sample = hold_reg;
            else
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
                load_sample = frame_reg;
`else
                load_sample = '0;
`endif
        end
        idx = (p_next < PW'(RESOLUTION)) ? IW'(PW'(RESOLUTION - 1) - p_next)
                                         : IW'(PW'(2 * RESOLUTION - 1) - p_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            p          <= '0;
            started    <= 1'b0;
            hold_valid <= 1'b0;
            hold_reg   <= '0;
            frame_reg  <= '0;
            ready_out  <= 1'b0;
            lrclk      <= 1'b0;
            sdata      <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (enable)
                state <= RUN;
            else if (state == RUN)
                state <= DRAIN;
            else if (to_idle)
                state <= IDLE;

            ready_out  <= enable && !hold_next;
            underrun   <= frame_start && !hold_valid;
            hold_valid <= hold_next;
            if (accept)
                hold_reg <= data_in;

            if (to_idle) begin
                p        <= '0;
                started  <= 1'b0;
                lrclk    <= 1'b0;
                sdata    <= 1'b0;
                hold_reg <= '0;
            end else if (fall_evt) begin
                p       <= p_next;
                started <= 1'b1;
                lrclk   <= lrclk_of(int'(p_next), RESOLUTION);
                sdata   <= load_sample[idx];
                if (frame_start)
                    frame_reg <= load_sample;
            end
        end
    end

endmodule
